// File: rtl/quad_encoder_gen_if.sv
// Step-request / quadrature-output bundle between upstream step logic and the generator.
// Upstream logic holds the master modport; the generator holds the slave modport.
interface quad_encoder_gen_if #(
  parameter int PEND_W = 8,
  parameter int POS_W  = 16
);
  logic                     i_step;
  logic                     i_cw;
  logic                     o_phase_a;
  logic                     o_phase_b;
  logic                     o_busy;
  logic                     o_ovf;
  logic signed [PEND_W-1:0] o_pending;
  logic signed [POS_W-1:0]  o_pos;

  modport master (
    output i_step, i_cw,
    input  o_phase_a, o_phase_b, o_busy, o_ovf, o_pending, o_pos
  );

  modport slave (
    input  i_step, i_cw,
    output o_phase_a, o_phase_b, o_busy, o_ovf, o_pending, o_pos
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator: replays queued CW/CCW step requests as evenly spaced Gray-code edges.
// First edge one clock after a request from idle; edges p_EDGE_CYCLES apart; saturating request queue.
module quad_encoder_gen #(
  parameter int p_EDGE_CYCLES    = 1000,
  parameter int p_EDGES_PER_STEP = 4,
  parameter int p_PEND_WIDTH     = 8,
  parameter int p_POS_WIDTH      = 16
) (
  input logic             CLK,
  input logic             RST_N,
  quad_encoder_gen_if.slave bus
);

  localparam int PW = p_PEND_WIDTH;
  localparam int EW = p_PEND_WIDTH + 2;
  localparam int TW = (p_EDGE_CYCLES > 1) ? $clog2(p_EDGE_CYCLES) : 1;
  localparam logic [TW-1:0]          T_LAST  = TW'(p_EDGE_CYCLES - 1);
  localparam logic [1:0]             EL_INIT = 2'(p_EDGES_PER_STEP - 1);
  localparam logic [p_POS_WIDTH-1:0] POS_ONE = p_POS_WIDTH'(1);
  localparam logic signed [EW-1:0]   EXT_ONE = EW'(1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state_q;
  logic [TW-1:0]           timer_q;
  logic [1:0]              edges_left_q;
  logic                    dir_q;
  logic [1:0]              phase_q;
  logic signed [PW-1:0]    pending_q;
  logic                    ovf_q;
  logic [p_POS_WIDTH-1:0]  pos_q;

  logic                    pend_nz;
  logic                    expiry;
  logic                    commit;
  logic                    emit;
  logic                    edge_dir;
  logic [1:0]              phase_d;
  logic [p_POS_WIDTH-1:0]  pos_d;
  logic signed [EW-1:0]    pend_ext;
  logic signed [EW-1:0]    req_ext;
  logic signed [EW-1:0]    com_ext;
  logic signed [EW-1:0]    sum_all;
  logic signed [EW-1:0]    sum_nreq;
  logic                    ovf_d;
  logic signed [PW-1:0]    pending_d;

  assign pend_nz  = |pending_q;
  assign expiry   = (state_q == S_WAIT) && (timer_q == T_LAST);
  assign commit   = ((state_q == S_IDLE) && pend_nz) ||
                    (expiry && (edges_left_q == 2'd0) && pend_nz);
  assign emit     = commit || (expiry && (edges_left_q != 2'd0));
  assign edge_dir = commit ? ~pending_q[PW-1] : dir_q;

  // CW walks 00->10->11->01, CCW walks the reverse; one phase flips per edge.
  assign phase_d  = edge_dir ? {~phase_q[0], phase_q[1]} : {phase_q[0], ~phase_q[1]};
  assign pos_d    = edge_dir ? (pos_q + POS_ONE) : (pos_q - POS_ONE);

  // Request and commit are summed two bits wider so a saturating request is detectable.
  always_comb begin
    pend_ext = {{2{pending_q[PW-1]}}, pending_q};
    req_ext  = '0;
    if (bus.i_step) begin
      req_ext = bus.i_cw ? EXT_ONE : '1;
    end
    com_ext = '0;
    if (commit) begin
      com_ext = pending_q[PW-1] ? '1 : EXT_ONE;
    end
    sum_all   = pend_ext + req_ext - com_ext;
    sum_nreq  = pend_ext - com_ext;
    ovf_d     = bus.i_step && (sum_all[EW-1:PW-1] != 3'b000) && (sum_all[EW-1:PW-1] != 3'b111);
    pending_d = ovf_d ? sum_nreq[PW-1:0] : sum_all[PW-1:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      edges_left_q <= '0;
      dir_q        <= 1'b0;
      phase_q      <= 2'b00;
      pending_q    <= '0;
      ovf_q        <= 1'b0;
      pos_q        <= '0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      if (emit) begin
        phase_q <= phase_d;
        pos_q   <= pos_d;
      end
      case (state_q)
        S_IDLE: begin
          if (commit) begin
            state_q      <= S_WAIT;
            dir_q        <= edge_dir;
            edges_left_q <= EL_INIT;
            timer_q      <= '0;
          end
        end
        S_WAIT: begin
          if (expiry) begin
            timer_q <= '0;
            if (edges_left_q != 2'd0) begin
              edges_left_q <= edges_left_q - 2'd1;
            end else if (commit) begin
              dir_q        <= edge_dir;
              edges_left_q <= EL_INIT;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_phase_a = phase_q[1];
  assign bus.o_phase_b = phase_q[0];
  assign bus.o_busy    = (state_q != S_IDLE) || pend_nz;
  assign bus.o_ovf     = ovf_q;
  assign bus.o_pending = pending_q;
  assign bus.o_pos     = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: 4-edge-per-step instance plus a 1-edge-per-step instance.
module tb_quad_encoder_gen;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;

  quad_encoder_gen_if #(.PEND_W(4), .POS_W(8)) bus ();
  quad_encoder_gen_if #(.PEND_W(4), .POS_W(8)) bus1 ();

  quad_encoder_gen #(
    .p_EDGE_CYCLES(4), .p_EDGES_PER_STEP(4), .p_PEND_WIDTH(4), .p_POS_WIDTH(8)
  ) u_dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  quad_encoder_gen #(
    .p_EDGE_CYCLES(4), .p_EDGES_PER_STEP(1), .p_PEND_WIDTH(4), .p_POS_WIDTH(8)
  ) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         k;
    bit         stp;
    bit         cw;
    bit         chk;
    logic [1:0] ab;
    bit         busy;
    int         pos;
    int         pend;
  } vec_t;

  vec_t vq[$];
  int   cur;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic void add(input int k, input bit stp, input bit cw, input bit c,
                              input logic [1:0] ab, input bit busy, input int pos, input int pend);
    vec_t v;
    v.k = k; v.stp = stp; v.cw = cw; v.chk = c;
    v.ab = ab; v.busy = busy; v.pos = pos; v.pend = pend;
    vq.push_back(v);
  endfunction

  task automatic do_reset();
    bus.i_step  = 1'b0;
    bus.i_cw    = 1'b0;
    bus1.i_step = 1'b0;
    bus1.i_cw   = 1'b0;
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  // k = clocks after the edge that sampled the first request; checks are taken after edge k.
  task automatic run_vecs(input string tag);
    cur = -1;
    foreach (vq[i]) begin
      if (vq[i].stp) begin
        while (cur < vq[i].k - 1) begin tick(); cur++; end
        bus.i_step = 1'b1;
        bus.i_cw   = vq[i].cw;
        tick();
        cur++;
        bus.i_step = 1'b0;
      end else begin
        while (cur < vq[i].k) begin tick(); cur++; end
      end
      if (vq[i].chk) begin
        chk($sformatf("%s k%0d ab", tag, vq[i].k), int'({bus.o_phase_a, bus.o_phase_b}), int'(vq[i].ab));
        chk($sformatf("%s k%0d busy", tag, vq[i].k), int'(bus.o_busy), int'(vq[i].busy));
        chk($sformatf("%s k%0d pos", tag, vq[i].k), int'($signed(bus.o_pos)), vq[i].pos);
        chk($sformatf("%s k%0d pend", tag, vq[i].k), int'($signed(bus.o_pending)), vq[i].pend);
        chk($sformatf("%s k%0d ovf", tag, vq[i].k), int'(bus.o_ovf), 0);
      end
    end
    vq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev_ab;
    int         edges;
    int         ovf_cnt;
    int         guard;
    int         exp_pend[10];

    checks = 0;
    errors = 0;
    bus.i_step = 1'b0; bus.i_cw = 1'b0;
    bus1.i_step = 1'b0; bus1.i_cw = 1'b0;
    RST_N = 1'b0;

    // Reset state, held and just after release
    tick();
    chk("rst ab", int'({bus.o_phase_a, bus.o_phase_b}), 0);
    chk("rst busy", int'(bus.o_busy), 0);
    chk("rst pos", int'($signed(bus.o_pos)), 0);
    chk("rst pend", int'($signed(bus.o_pending)), 0);
    chk("rst ovf", int'(bus.o_ovf), 0);
    RST_N = 1'b1;
    tick();
    chk("rel ab", int'({bus.o_phase_a, bus.o_phase_b}), 0);
    chk("rel busy", int'(bus.o_busy), 0);

    // Single CW step
    add(0,  1, 1, 1, 2'b00, 1, 0, 1);
    add(1,  0, 0, 1, 2'b10, 1, 1, 0);
    add(4,  0, 0, 1, 2'b10, 1, 1, 0);
    add(5,  0, 0, 1, 2'b11, 1, 2, 0);
    add(8,  0, 0, 1, 2'b11, 1, 2, 0);
    add(9,  0, 0, 1, 2'b01, 1, 3, 0);
    add(13, 0, 0, 1, 2'b00, 1, 4, 0);
    add(16, 0, 0, 1, 2'b00, 1, 4, 0);
    add(17, 0, 0, 1, 2'b00, 0, 4, 0);
    run_vecs("cw1");

    // CW step then a CCW request mid-step: CW completes, then CCW replays
    do_reset();
    add(0,  1, 1, 1, 2'b00, 1, 0, 1);
    add(1,  0, 0, 1, 2'b10, 1, 1, 0);
    add(3,  1, 0, 1, 2'b10, 1, 1, -1);
    add(5,  0, 0, 1, 2'b11, 1, 2, -1);
    add(9,  0, 0, 1, 2'b01, 1, 3, -1);
    add(13, 0, 0, 1, 2'b00, 1, 4, -1);
    add(16, 0, 0, 1, 2'b00, 1, 4, -1);
    add(17, 0, 0, 1, 2'b01, 1, 3, 0);
    add(20, 0, 0, 1, 2'b01, 1, 3, 0);
    add(21, 0, 0, 1, 2'b11, 1, 2, 0);
    add(25, 0, 0, 1, 2'b10, 1, 1, 0);
    add(29, 0, 0, 1, 2'b00, 1, 0, 0);
    add(32, 0, 0, 1, 2'b00, 1, 0, 0);
    add(33, 0, 0, 1, 2'b00, 0, 0, 0);
    run_vecs("rev");

    // Ten back-to-back CW requests saturate the 4-bit pending counter
    do_reset();
    exp_pend = '{1, 1, 2, 3, 4, 5, 6, 7, 7, 7};
    prev_ab = 2'b00;
    edges   = 0;
    ovf_cnt = 0;
    bus.i_step = 1'b1;
    bus.i_cw   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sat pend c%0d", i), int'($signed(bus.o_pending)), exp_pend[i]);
      if (bus.o_ovf) ovf_cnt++;
      if ({bus.o_phase_a, bus.o_phase_b} != prev_ab) edges++;
      prev_ab = {bus.o_phase_a, bus.o_phase_b};
    end
    bus.i_step = 1'b0;
    guard = 0;
    while (bus.o_busy && guard < 400) begin
      tick();
      guard++;
      if (bus.o_ovf) ovf_cnt++;
      if ({bus.o_phase_a, bus.o_phase_b} != prev_ab) edges++;
      prev_ab = {bus.o_phase_a, bus.o_phase_b};
    end
    chk("sat idle_in_time", int'(guard < 400), 1);
    chk("sat ovf pulses", ovf_cnt, 2);
    chk("sat edges", edges, 32);
    chk("sat pos", int'($signed(bus.o_pos)), 32);
    chk("sat ab", int'({bus.o_phase_a, bus.o_phase_b}), 0);

    // Reset between the 2nd and 3rd edge of a step
    do_reset();
    bus.i_step = 1'b1;
    bus.i_cw   = 1'b1;
    tick();
    bus.i_step = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid ab before", int'({bus.o_phase_a, bus.o_phase_b}), 3);
    chk("mid pos before", int'($signed(bus.o_pos)), 2);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid ab async", int'({bus.o_phase_a, bus.o_phase_b}), 0);
    chk("mid pos async", int'($signed(bus.o_pos)), 0);
    chk("mid busy async", int'(bus.o_busy), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    edges = 0;
    prev_ab = 2'b00;
    for (int i = 0; i < 30; i++) begin
      tick();
      if ({bus.o_phase_a, bus.o_phase_b} != prev_ab) edges++;
      prev_ab = {bus.o_phase_a, bus.o_phase_b};
    end
    chk("mid edges after", edges, 0);
    chk("mid pos after", int'($signed(bus.o_pos)), 0);
    chk("mid busy after", int'(bus.o_busy), 0);

    // One edge per step: rest state advances through the sequence
    do_reset();
    bus1.i_step = 1'b1;
    bus1.i_cw   = 1'b1;
    tick();
    tick();
    bus1.i_step = 1'b0;
    chk("eps1 k1 ab", int'({bus1.o_phase_a, bus1.o_phase_b}), 2);
    chk("eps1 k1 pos", int'($signed(bus1.o_pos)), 1);
    chk("eps1 k1 pend", int'($signed(bus1.o_pending)), 1);
    for (int i = 0; i < 3; i++) tick();
    chk("eps1 k4 ab", int'({bus1.o_phase_a, bus1.o_phase_b}), 2);
    tick();
    chk("eps1 k5 ab", int'({bus1.o_phase_a, bus1.o_phase_b}), 3);
    chk("eps1 k5 pos", int'($signed(bus1.o_pos)), 2);
    for (int i = 0; i < 3; i++) tick();
    chk("eps1 k8 busy", int'(bus1.o_busy), 1);
    tick();
    chk("eps1 k9 busy", int'(bus1.o_busy), 0);
    chk("eps1 k9 ab", int'({bus1.o_phase_a, bus1.o_phase_b}), 3);
    chk("eps1 k9 pos", int'($signed(bus1.o_pos)), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
